wb_uart_slave_bridge: RTL
=========================

Name: wb_uart_slave_bridge

Overview:
Parametrised Wishbone classic slave front-end for the UART core register file. It replaces the fixed 8-bit/3-bit-address bus attach with a configurable bus that supports:
- 8- or 32-bit data width;
- byte-lane decode;
- programmable wait states;
- an error response for illegal accesses;
- cycle abort.
It converts each bus cycle into a single-cycle read or write strobe toward the UART registers and returns a registered acknowledge.

Parameters:
DATA_WIDTH, 8, Wishbone data width; legal values 8 or 32.
ADDR_WIDTH, 3, Wishbone address width; 3 when DATA_WIDTH=8, 5 when DATA_WIDTH=32.
WAIT_STATES, 1, extra cycles between register strobe and ack; legal 0..7.
REG_COUNT, 8, number of implemented registers; legal 1..8; higher indices error.

Ports:
clk  input  1  system clock, all logic on rising edge
wb_rst_i  input  1  asynchronous active-high reset
wb_adr_i  input  ADDR_WIDTH  byte address
wb_dat_i  input  DATA_WIDTH  write data
wb_dat_o  output  DATA_WIDTH  read data, valid while wb_ack_o=1
wb_we_i  input  1  1=write, 0=read
wb_stb_i  input  1  strobe
wb_cyc_i  input  1  bus cycle valid
wb_sel_i  input  DATA_WIDTH/8  byte-lane select
wb_ack_o  output  1  normal termination, one-cycle pulse
wb_err_o  output  1  error termination, one-cycle pulse
reg_adr_o  output  3  register index to UART core
reg_wdat_o  output  8  register write data
reg_rdat_i  input  8  register read data, combinational from reg_adr_o
reg_we_o  output  1  one-cycle write strobe
reg_re_o  output  1  one-cycle read strobe
int_i  input  1  UART interrupt request
int_o  output  1  registered interrupt to bus side

Behaviour:
- Reset is asynchronous and active-high on wb_rst_i, with one clock clk. While reset is asserted:
  - all outputs are 0;
  - the FSM is in IDLE;
  - the wait counter is 0.
  Reset asserted mid-transaction abandons the transaction; no ack or err is issued afterwards.
- Request means wb_cyc_i & wb_stb_i, sampled in IDLE at edge t. On acceptance, address, we, sel and the selected data byte are latched.
- Register index and lane:
  - DATA_WIDTH=8: index = wb_adr_i[2:0]; wb_sel_i is ignored; lane 0.
  - DATA_WIDTH=32: index = wb_adr_i[4:2]. wb_sel_i must be one-hot; its set bit selects the lane k. wb_adr_i[1:0] is ignored.
- Illegal access: wb_sel_i not one-hot (32-bit mode), or index >= REG_COUNT. Response:
  - FSM goes to ERR;
  - wb_err_o=1 for exactly cycle t+1;
  - no strobe and no ack;
  - return to IDLE.
- FSM states and transitions:
  - IDLE: on legal request, go to ACCESS.
  - ACCESS (cycle t+1): reg_we_o or reg_re_o =1 for exactly this cycle. reg_adr_o = index; reg_wdat_o = byte k of wb_dat_i. On a read, reg_rdat_i is captured at the edge ending ACCESS.
  - WAIT: lasts WAIT_STATES cycles, counted by a 3-bit down-counter. WAIT is skipped when WAIT_STATES=0.
  - ACK (cycle t+2+WAIT_STATES): wb_ack_o=1 for one cycle, then IDLE.
- Read data: wb_dat_o carries the captured byte on lane k (lane 0 in 8-bit mode), with all other lanes 0. The value holds until the next read ack. Write acks leave wb_dat_o unchanged.
- Outputs reg_adr_o and reg_wdat_o hold their last value between accesses.
- Abort: wb_cyc_i=0 sampled in ACCESS or WAIT → next state is IDLE with no ack. A strobe already issued is not retracted.
- A request still present in the cycle after ACK is accepted as a new access, giving back-to-back throughput of one access per 3+WAIT_STATES cycles.
- wb_ack_o and wb_err_o are never high together.
- int_o: int_i registered through one flop; 1-cycle latency.

Test Plan:
- 8-bit, WAIT_STATES=1: write adr 3, data 0x83 → reg_we_o high at t+1 only, reg_adr_o=3, reg_wdat_o=0x83; wb_ack_o high at t+3 only.
- 8-bit, WAIT_STATES=1: read adr 5 with reg_rdat_i=0x60 → reg_re_o at t+1; at t+3 wb_ack_o=1 and wb_dat_o=0x60.
- 32-bit, WAIT_STATES=0:
  - write adr 0x0C, sel 4'b0100, dat 0x00AB0000 → reg_adr_o=3, reg_wdat_o=0xAB, ack at t+2;
  - read same register with reg_rdat_i=0x5A → wb_dat_o=0x005A0000.
- 32-bit, error cases, each giving wb_err_o at t+1, no strobe and no ack:
  - sel 4'b0011;
  - sel 4'b0000;
  - with REG_COUNT=7, adr 0x1C sel 4'b0001.
- WAIT_STATES=3, abort: drop wb_cyc_i at t+2 → no ack; a following read of adr 1 completes normally with ack at t'+5.
- Reset: assert wb_rst_i asynchronously mid-WAIT → all outputs 0 immediately; after release the next access acks normally. Also int_i 0→1 → int_o=1 one cycle later.

Source files
------------

// File: rtl/wb_uart_slave_bridge.sv
// ---------------------------------------------------------------------------
// wb_uart_slave_bridge
//
// Wishbone classic slave front-end for the UART register file. Each accepted
// bus cycle becomes one single-cycle read or write strobe toward the UART
// registers. The cycle ends with a registered acknowledge after a
// programmable number of wait states. Illegal accesses end with an error
// pulse instead.
//
// Parameters:
//   DATA_WIDTH  - bus data width, 8 or 32
//   ADDR_WIDTH  - bus address width, 3 (8-bit bus) or 5 (32-bit bus)
//   WAIT_STATES - extra cycles between register strobe and ack, 0..7
//   REG_COUNT   - number of implemented registers, 1..8
//
// Ports:
//   clk, wb_rst_i        - clock and asynchronous active-high reset
//   wb_adr_i, wb_dat_i   - byte address and write data
//   wb_we_i, wb_stb_i    - write enable and strobe
//   wb_cyc_i, wb_sel_i   - cycle valid and byte-lane select
//   wb_dat_o             - read data, valid while wb_ack_o is high
//   wb_ack_o, wb_err_o   - normal and error termination pulses
//   reg_adr_o            - register index toward the UART core
//   reg_wdat_o           - register write data
//   reg_rdat_i           - register read data, combinational from reg_adr_o
//   reg_we_o, reg_re_o   - single-cycle register write/read strobes
//   int_i, int_o         - UART interrupt in, registered interrupt out
// ---------------------------------------------------------------------------
module wb_uart_slave_bridge #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 3,
    parameter int WAIT_STATES = 1,
    parameter int REG_COUNT   = 8
) (
    input  logic                    clk,
    input  logic                    wb_rst_i,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic                    wb_we_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_cyc_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic [2:0]              reg_adr_o,
    output logic [7:0]              reg_wdat_o,
    input  logic [7:0]              reg_rdat_i,
    output logic                    reg_we_o,
    output logic                    reg_re_o,
    input  logic                    int_i,
    output logic                    int_o
);

    localparam int           LANES     = DATA_WIDTH / 8;
    localparam logic [3:0]   REG_LIMIT = 4'(REG_COUNT);
    localparam logic [2:0]   WAIT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_ACK,
        ST_ERR
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              wait_cnt_q, wait_cnt_d;
    logic                    we_q, we_d;
    logic [1:0]              lane_q, lane_d;
    logic [2:0]              reg_adr_q, reg_adr_d;
    logic [7:0]              reg_wdat_q, reg_wdat_d;
    logic [7:0]              rdat_q, rdat_d;
    logic [DATA_WIDTH-1:0]   dat_o_q, dat_o_d;
    logic                    int_q, int_d;

    logic       req;
    logic [2:0] req_idx;
    logic [1:0] req_lane;
    logic       sel_ok;
    logic       idx_ok;
    logic       req_legal;
    logic [7:0] req_byte;
    logic [7:0] rd_byte;

    // Register index and byte lane depend on the bus width. On the wide bus
    // the lane comes from a one-hot select and the low address bits are
    // don't-care; on the narrow bus the select is ignored.
    generate
        if (DATA_WIDTH == 32) begin : g_wide
            logic unused_adr_lsb;
            assign unused_adr_lsb = ^wb_adr_i[1:0];
            assign req_idx        = wb_adr_i[4:2];
            assign sel_ok         = $onehot(wb_sel_i);
            always_comb begin
                req_lane = 2'd0;
                for (int i = 0; i < 4; i++) begin
                    if (wb_sel_i[i]) begin
                        req_lane = 2'(i);
                    end
                end
            end
        end else begin : g_narrow
            logic unused_sel;
            assign unused_sel = ^wb_sel_i;
            assign req_idx    = wb_adr_i[2:0];
            assign sel_ok     = 1'b1;
            assign req_lane   = 2'd0;
        end
    endgenerate

    // Request qualification and selection of the write byte from the
    // addressed lane.
    always_comb begin
        req       = wb_cyc_i & wb_stb_i;
        idx_ok    = ({1'b0, req_idx} < REG_LIMIT);
        req_legal = sel_ok & idx_ok;
        req_byte  = wb_dat_i[7:0];
        for (int i = 0; i < LANES; i++) begin
            if (req_lane == 2'(i)) begin
                req_byte = wb_dat_i[8*i +: 8];
            end
        end
    end

    // State register plus all datapath flops.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 3'd0;
            we_q       <= 1'b0;
            lane_q     <= 2'd0;
            reg_adr_q  <= 3'd0;
            reg_wdat_q <= 8'd0;
            rdat_q     <= 8'd0;
            dat_o_q    <= '0;
            int_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            we_q       <= we_d;
            lane_q     <= lane_d;
            reg_adr_q  <= reg_adr_d;
            reg_wdat_q <= reg_wdat_d;
            rdat_q     <= rdat_d;
            dat_o_q    <= dat_o_d;
            int_q      <= int_d;
        end
    end

    // Next-state logic. Dropping wb_cyc_i during ACCESS or WAIT abandons the
    // cycle without a termination; the strobe already issued stands.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = req_legal ? ST_ACCESS : ST_ERR;
                end
            end
            ST_ACCESS: begin
                if (!wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (WAIT_STATES == 0) begin
                    state_d = ST_ACK;
                end else begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WAIT_INIT;
                end
            end
            ST_WAIT: begin
                if (!wb_cyc_i) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = 3'd0;
                end else if (wait_cnt_q == 3'd0) begin
                    state_d = ST_ACK;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath. Request fields are latched only for legal accesses so the
    // register-side outputs hold their last value otherwise. Read data is
    // captured at the end of ACCESS and published on the bus when ACK is
    // entered, so an aborted read never disturbs wb_dat_o. With no wait
    // states ACK follows ACCESS directly and the core data is used as-is.
    always_comb begin
        we_d       = we_q;
        lane_d     = lane_q;
        reg_adr_d  = reg_adr_q;
        reg_wdat_d = reg_wdat_q;
        rdat_d     = rdat_q;
        dat_o_d    = dat_o_q;
        int_d      = int_i;
        rd_byte    = (state_q == ST_ACCESS) ? reg_rdat_i : rdat_q;

        if (state_q == ST_IDLE && req && req_legal) begin
            we_d       = wb_we_i;
            lane_d     = req_lane;
            reg_adr_d  = req_idx;
            reg_wdat_d = req_byte;
        end

        if (state_q == ST_ACCESS) begin
            rdat_d = reg_rdat_i;
        end

        if (state_q != ST_ACK && state_d == ST_ACK && !we_q) begin
            dat_o_d = '0;
            for (int i = 0; i < LANES; i++) begin
                if (lane_q == 2'(i)) begin
                    dat_o_d[8*i +: 8] = rd_byte;
                end
            end
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        wb_ack_o   = (state_q == ST_ACK);
        wb_err_o   = (state_q == ST_ERR);
        reg_we_o   = (state_q == ST_ACCESS) &  we_q;
        reg_re_o   = (state_q == ST_ACCESS) & ~we_q;
        reg_adr_o  = reg_adr_q;
        reg_wdat_o = reg_wdat_q;
        wb_dat_o   = dat_o_q;
        int_o      = int_q;
    end

endmodule
